systolic_phase_counter: RTL

Parametrised phase sequencer built around a generalised enable/clear counter. It drives a systolic array tile through weight load, compute streaming and result drain, with programmable per-phase lengths. It sits between the tile controller and the PE array and provides per-phase enables, the in-phase cycle index and a completion pulse. It replaces the fixed-width free-running enable counters with one configurable, pausable, abortable block.

---
 rtl/systolic_phase_counter_pkg.sv | 43 ++++
 rtl/systolic_phase_counter_if.sv | 36 +++
 rtl/systolic_phase_counter_counter_param_en.sv | 30 +++
 rtl/systolic_phase_counter.sv | 115 +++++++++++
 4 files changed

// File: rtl/systolic_phase_counter_pkg.sv
// Shared definitions for the systolic phase sequencer.
//   - State encoding of the sequencer (also the value driven on the phase output).
//   - Default counter width and default array dimension.
//   - next_phase(): returns the next phase with a non-zero length, in the
//     order LOAD, COMPUTE, DRAIN. It returns DONE when no such phase remains.
package systolic_phase_counter_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int DEF_CW = 8;
  localparam int DEF_N  = 64;

  // Zero-length phases are skipped here, so they are never entered.
  // The inputs are "length is non-zero" flags for each phase.
  function automatic logic [2:0] next_phase(input logic [2:0] cur,
                                            input logic       load_nz,
                                            input logic       comp_nz,
                                            input logic       drain_nz);
    logic [2:0] nxt;
    nxt = ST_DONE;
    case (cur)
      ST_IDLE: begin
        if (load_nz)       nxt = ST_LOAD;
        else if (comp_nz)  nxt = ST_COMPUTE;
        else if (drain_nz) nxt = ST_DRAIN;
      end
      ST_LOAD: begin
        if (comp_nz)       nxt = ST_COMPUTE;
        else if (drain_nz) nxt = ST_DRAIN;
      end
      ST_COMPUTE: begin
        if (drain_nz)      nxt = ST_DRAIN;
      end
      default:             nxt = ST_DONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/systolic_phase_counter_if.sv
// Control and status bundle between the tile controller and the sequencer.
//   master modport: the tile controller. It drives start, abort, pause and the
//                   cfg_* lengths, and observes the status.
//   slave modport : the sequencer.
// Handshake: there is no valid/ready pair. start is a level that is sampled
// on each clock edge while the sequencer is in IDLE. Any other state ignores
// it and does not queue it. abort and pause are levels that act on the next
// edge. The phase output is the raw FSM state, so checkers can bind to it.
interface systolic_phase_counter_if #(
  parameter int CW = systolic_phase_counter_pkg::DEF_CW
);
  logic          start;
  logic          abort;
  logic          pause;
  logic [CW-1:0] cfg_load_len;
  logic [CW-1:0] cfg_comp_len;
  logic [CW-1:0] cfg_drain_len;
  logic          busy;
  logic [2:0]    phase;
  logic [CW-1:0] phase_count;
  logic          load_en;
  logic          comp_en;
  logic          drain_en;
  logic          last;
  logic          done;

  modport master (
    output start, abort, pause, cfg_load_len, cfg_comp_len, cfg_drain_len,
    input  busy, phase, phase_count, load_en, comp_en, drain_en, last, done
  );

  modport slave (
    input  start, abort, pause, cfg_load_len, cfg_comp_len, cfg_drain_len,
    output busy, phase, phase_count, load_en, comp_en, drain_en, last, done
  );
endinterface

// File: rtl/systolic_phase_counter_counter_param_en.sv
// Generalised CW-bit enable/clear/hold counter.
// Ports:
//   i_clk, i_rstn : clock and asynchronous active-low reset
//   i_en          : counting enabled. When low, the count is forced to 0.
//   i_clear       : synchronous clear to 0. It has priority over everything else.
//   i_hold        : freeze the count while enabled
//   o_count       : current count
module counter_param_en #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_en,
  input  logic          i_clear,
  input  logic          i_hold,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)       r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (!i_en)    r_count <= '0;
    else if (!i_hold)  r_count <= r_count + CW'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/systolic_phase_counter.sv
// Phase sequencer for a systolic array tile. It steps through weight LOAD,
// COMPUTE streaming and result DRAIN, then a one-cycle DONE, using phase
// lengths that are latched at start. The sequence can be paused or aborted.
// Ports:
//   clk, rstn : clock and asynchronous active-low reset
//   bus       : slave modport of systolic_phase_counter_if
//               (start/abort/pause/cfg_* in; busy/phase/phase_count/
//                load_en/comp_en/drain_en/last/done out)
module systolic_phase_counter
  import systolic_phase_counter_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int N  = DEF_N
) (
  input  logic                     clk,
  input  logic                     rstn,
  systolic_phase_counter_if.slave  bus
);

  localparam logic [CW-1:0] LEN_DEF = CW'(N);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [CW-1:0] r_load_len;
  logic [CW-1:0] r_comp_len;
  logic [CW-1:0] r_drain_len;
  logic [CW-1:0] w_cur_len;
  logic [CW-1:0] w_count;
  logic          w_active;
  logic          w_run;
  logic          w_last;
  logic          w_abort;
  logic          w_clear;

  assign w_active = (r_state == ST_LOAD) || (r_state == ST_COMPUTE) ||
                    (r_state == ST_DRAIN);

  always_comb begin
    w_cur_len = '0;
    case (r_state)
      ST_LOAD:    w_cur_len = r_load_len;
      ST_COMPUTE: w_cur_len = r_comp_len;
      ST_DRAIN:   w_cur_len = r_drain_len;
      default:    w_cur_len = '0;
    endcase
  end

  assign w_run   = w_active && !bus.pause;
  // Only active phases reach this compare. Their length is never 0,
  // so len-1 cannot underflow.
  assign w_last  = w_run && (w_count == (w_cur_len - CW'(1)));
  assign w_abort = w_active && bus.abort;
  // The count restarts at 0 on every phase boundary and on abort.
  assign w_clear = w_abort || w_last;

  // Outside the active phases the count is disabled, which holds it at 0.
  counter_param_en #(.CW(CW)) u_counter (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_en    (w_active),
    .i_clear (w_clear),
    .i_hold  (bus.pause),
    .o_count (w_count)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start)
          w_next = next_phase(ST_IDLE, |bus.cfg_load_len, |bus.cfg_comp_len,
                              |bus.cfg_drain_len);
      end
      ST_LOAD, ST_COMPUTE, ST_DRAIN: begin
        if (w_abort)
          w_next = ST_IDLE;
        else if (w_last)
          w_next = next_phase(r_state, |r_load_len, |r_comp_len, |r_drain_len);
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Lengths are captured only when a sequence is accepted. Any change made
  // while a sequence runs has no effect until the next start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_load_len  <= LEN_DEF;
      r_comp_len  <= LEN_DEF;
      r_drain_len <= LEN_DEF;
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_load_len  <= bus.cfg_load_len;
      r_comp_len  <= bus.cfg_comp_len;
      r_drain_len <= bus.cfg_drain_len;
    end
  end

  // Outputs come from registers. The only path from an input to an output
  // is the pause gating, which reaches the enables and last.
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.phase       = r_state;
  assign bus.phase_count = w_count;
  assign bus.load_en     = (r_state == ST_LOAD)    && !bus.pause;
  assign bus.comp_en     = (r_state == ST_COMPUTE) && !bus.pause;
  assign bus.drain_en    = (r_state == ST_DRAIN)   && !bus.pause;
  assign bus.last        = w_last;
  assign bus.done        = (r_state == ST_DONE);

endmodule
